// File: rtl/decode_stage_if.sv
// decode_stage_if: IF-side handshake, EX load-hazard sideband and decoded ID bundle of decode_stage.
interface decode_stage_if #(
    parameter int XLEN      = 32,
    parameter int PC_W      = 32,
    parameter int REG_IDX_W = 5
);
    logic                 if_valid;
    logic                 if_ready;
    logic [PC_W-1:0]      if_pc;
    logic [31:0]          if_instr;
    logic                 ex_load_valid;
    logic [REG_IDX_W-1:0] ex_load_rd;
    logic                 ex_ready;
    logic                 id_valid;
    logic [PC_W-1:0]      id_pc;
    logic [REG_IDX_W-1:0] id_rs1_idx;
    logic [REG_IDX_W-1:0] id_rs2_idx;
    logic [REG_IDX_W-1:0] id_rd_idx;
    logic                 id_rs1_en;
    logic                 id_rs2_en;
    logic                 id_rd_en;
    logic [XLEN-1:0]      id_imm;
    logic [2:0]           id_fmt;
    logic [2:0]           id_fun3;
    logic [6:0]           id_fun7;
    logic                 id_muldiv;
    logic                 id_illegal;

    modport slave (
        input  if_valid, if_pc, if_instr, ex_load_valid, ex_load_rd, ex_ready,
        output if_ready, id_valid, id_pc, id_rs1_idx, id_rs2_idx, id_rd_idx,
               id_rs1_en, id_rs2_en, id_rd_en, id_imm, id_fmt, id_fun3, id_fun7,
               id_muldiv, id_illegal
    );

    modport master (
        output if_valid, if_pc, if_instr, ex_load_valid, ex_load_rd, ex_ready,
        input  if_ready, id_valid, id_pc, id_rs1_idx, id_rs2_idx, id_rd_idx,
               id_rs1_en, id_rs2_en, id_rd_en, id_imm, id_fmt, id_fun3, id_fun7,
               id_muldiv, id_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I decode stage with skid buffer, load-use stall and flush.
// Defining DEC_RV32M_EN makes OP with fun7=0000001 a legal M-extension operation.
module decode_stage #(
    parameter int XLEN      = 32,
    parameter int PC_W      = 32,
    parameter int REG_IDX_W = 5
) (
    input logic clk,
    input logic rst,
    input logic flush,
    decode_stage_if.slave bus
);
    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic                 rs1_en;
        logic                 rs2_en;
        logic                 rd_en;
        logic [XLEN-1:0]      imm;
        logic [2:0]           fmt;
        logic [2:0]           fun3;
        logic [6:0]           fun7;
        logic                 muldiv;
        logic                 illegal;
    } bundle_t;

    bundle_t         dec, q;
    logic            id_valid;
    logic            skid_valid;
    logic [PC_W-1:0] skid_pc;
    logic [31:0]     skid_instr;
    logic [31:0]     instr;
    logic [31:0]     imm32;
    logic [6:0]      op;
    logic            muldiv, fun7_ok;
    logic            head_valid, hazard, load, if_xfer;

    always_comb begin
        instr      = skid_valid ? skid_instr : bus.if_instr;
        head_valid = skid_valid | bus.if_valid;
        op         = instr[6:0];
`ifdef DEC_RV32M_EN
        muldiv     = (op == 7'b0110011) && (instr[31:25] == 7'b0000001);
`else
        muldiv     = 1'b0;
`endif
        fun7_ok    = (instr[31:25] == 7'b0000000) || (instr[31:25] == 7'b0100000) || muldiv;
        dec        = '0;
        dec.pc     = skid_valid ? skid_pc : bus.if_pc;
        dec.rs1    = REG_IDX_W'(instr[19:15]);
        dec.rs2    = REG_IDX_W'(instr[24:20]);
        dec.rd     = REG_IDX_W'(instr[11:7]);
        dec.fun3   = instr[14:12];
        dec.fun7   = instr[31:25];
        dec.muldiv = muldiv;
        case (op)
            7'b0110011: begin dec.fmt = 3'd0; {dec.rs1_en, dec.rs2_en, dec.rd_en} = 3'b111; dec.illegal = ~fun7_ok; end
            7'b0010011, 7'b0000011, 7'b1100111: begin dec.fmt = 3'd1; {dec.rs1_en, dec.rs2_en, dec.rd_en} = 3'b101; end
            7'b0100011: begin dec.fmt = 3'd2; {dec.rs1_en, dec.rs2_en, dec.rd_en} = 3'b110; end
            7'b1100011: begin dec.fmt = 3'd3; {dec.rs1_en, dec.rs2_en, dec.rd_en} = 3'b110; end
            7'b0110111, 7'b0010111: begin dec.fmt = 3'd4; {dec.rs1_en, dec.rs2_en, dec.rd_en} = 3'b001; end
            7'b1101111: begin dec.fmt = 3'd5; {dec.rs1_en, dec.rs2_en, dec.rd_en} = 3'b001; end
            7'b0001111, 7'b1110011: dec.fmt = 3'd6;
            default: dec.illegal = 1'b1;
        endcase
        if (instr[1:0] != 2'b11)
            dec.illegal = 1'b1;
        imm32 = dec.fmt == 3'd1 ? {{20{instr[31]}}, instr[31:20]} :
                dec.fmt == 3'd2 ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
                dec.fmt == 3'd3 ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
                dec.fmt == 3'd4 ? {instr[31:12], 12'b0} :
                dec.fmt == 3'd5 ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
                32'd0;
        dec.imm   = XLEN'($signed(imm32));
        dec.rd_en = dec.rd_en & (instr[11:7] != 5'd0);
        // Illegal words still issue so EX can trap, but must not touch the register file.
        if (dec.illegal) begin
            dec.fmt    = 3'd7;
            dec.rs1_en = 1'b0;
            dec.rs2_en = 1'b0;
            dec.rd_en  = 1'b0;
            dec.imm    = '0;
            dec.muldiv = 1'b0;
        end
    end

    assign hazard = bus.ex_load_valid && (bus.ex_load_rd != '0) &&
                    ((dec.rs1_en && dec.rs1 == bus.ex_load_rd) || (dec.rs2_en && dec.rs2 == bus.ex_load_rd));
    assign load        = head_valid & ~hazard & (~id_valid | bus.ex_ready);
    assign bus.if_ready = ~skid_valid & ~rst;
    assign if_xfer     = bus.if_valid & bus.if_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            q          <= '0;
            id_valid   <= 1'b0;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else if (flush) begin
            id_valid   <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (load) begin
                q        <= dec;
                id_valid <= 1'b1;
            end else if (id_valid && bus.ex_ready) begin
                id_valid <= 1'b0;
            end
            if (load && skid_valid) begin
                skid_valid <= 1'b0;
            end else if (if_xfer && !load) begin
                skid_valid <= 1'b1;
                skid_pc    <= bus.if_pc;
                skid_instr <= bus.if_instr;
            end
        end
    end

    assign bus.id_valid   = id_valid;
    assign bus.id_pc      = q.pc;
    assign bus.id_rs1_idx = q.rs1;
    assign bus.id_rs2_idx = q.rs2;
    assign bus.id_rd_idx  = q.rd;
    assign bus.id_rs1_en  = q.rs1_en;
    assign bus.id_rs2_en  = q.rs2_en;
    assign bus.id_rd_en   = q.rd_en;
    assign bus.id_imm     = q.imm;
    assign bus.id_fmt     = q.fmt;
    assign bus.id_fun3    = q.fun3;
    assign bus.id_fun7    = q.fun7;
    assign bus.id_muldiv  = q.muldiv;
    assign bus.id_illegal = q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed plus randomized checks of decode_stage against a queue-based reference model.
module tb_decode_stage;
    localparam int XLEN = 32;
    localparam int PC_W = 32;
    localparam int RW   = 5;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct packed {
        logic [2:0]  fmt;
        logic        rs1_en;
        logic        rs2_en;
        logic        rd_en;
        logic        muldiv;
        logic        illegal;
        logic [63:0] imm;
    } dec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(XLEN), .PC_W(PC_W), .REG_IDX_W(RW)) bus();
    decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .REG_IDX_W(RW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus)
    );

    int   n_vec = 0;
    int   n_err = 0;
    ent_t pend[$];
    ent_t issued[$];
    ent_t m_out = '0;
    logic m_valid = 1'b0;
    logic m_acc = 1'b0;
    logic [31:0] next_pc = 32'h1000;
    logic [6:0]  ops[11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h0F, 7'h73};

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Decoding from the ISA field rules, with immediates built by plain arithmetic.
    function automatic dec_t ref_dec(logic [31:0] w);
        dec_t   d;
        longint s;
        logic [6:0] op, f7;
        bit m_ok;
        d  = '0;
        s  = longint'($signed(w));
        op = w[6:0];
        f7 = w[31:25];
`ifdef DEC_RV32M_EN
        m_ok = 1'b1;
`else
        m_ok = 1'b0;
`endif
        if (op == 7'h33) begin
            d.rs1_en = 1; d.rs2_en = 1; d.rd_en = 1;
            d.muldiv  = m_ok && f7 == 7'h01;
            d.illegal = !(f7 == 7'h00 || f7 == 7'h20 || d.muldiv);
        end else if (op == 7'h13 || op == 7'h03 || op == 7'h67) begin
            d.fmt = 1; d.rs1_en = 1; d.rd_en = 1;
            d.imm = 64'(s >>> 20);
        end else if (op == 7'h23) begin
            d.fmt = 2; d.rs1_en = 1; d.rs2_en = 1;
            d.imm = 64'(((s >>> 25) <<< 5) + longint'(w[11:7]));
        end else if (op == 7'h63) begin
            d.fmt = 3; d.rs1_en = 1; d.rs2_en = 1;
            d.imm = 64'(((s >>> 31) <<< 12) + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2);
        end else if (op == 7'h37 || op == 7'h17) begin
            d.fmt = 4; d.rd_en = 1;
            d.imm = 64'((s >>> 12) <<< 12);
        end else if (op == 7'h6F) begin
            d.fmt = 5; d.rd_en = 1;
            d.imm = 64'(((s >>> 31) <<< 20) + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2);
        end else if (op == 7'h0F || op == 7'h73) begin
            d.fmt = 6;
        end else begin
            d.illegal = 1;
        end
        if (d.illegal) begin
            d = '0;
            d.fmt = 7;
            d.illegal = 1;
        end
        if (w[11:7] == 5'd0)
            d.rd_en = 0;
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 12);
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        w[11:7]  = 5'($urandom_range(0, 7));
        if (k < 11) begin
            w[6:0] = ops[k];
            if (k == 0) begin
                case ($urandom_range(0, 3))
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    2: w[31:25] = 7'h01;
                    default: ;
                endcase
            end
        end
        return w;
    endfunction

    // Advance one clock: predict the next state from the driven inputs, then compare at the falling edge.
    task automatic cyc();
        ent_t inc, h;
        dec_t hd, e;
        logic has, hz, ld, cons;
        inc   = '{pc: bus.if_pc, instr: bus.if_instr};
        m_acc = bus.if_valid && pend.size() == 0 && !rst;
        cons  = m_valid && bus.ex_ready;
        if (rst) begin
            pend.delete();
            m_valid = 0;
            m_out   = '0;
        end else begin
            if (cons)
                issued.push_back(m_out);
            if (flush) begin
                pend.delete();
                m_valid = 0;
            end else begin
                has = pend.size() > 0 || bus.if_valid;
                h   = pend.size() > 0 ? pend[0] : inc;
                hd  = ref_dec(h.instr);
                hz  = bus.ex_load_valid && bus.ex_load_rd != 0 &&
                      ((hd.rs1_en && h.instr[19:15] == bus.ex_load_rd) || (hd.rs2_en && h.instr[24:20] == bus.ex_load_rd));
                ld  = has && !hz && (!m_valid || bus.ex_ready);
                if (m_acc)
                    pend.push_back(inc);
                if (ld) begin
                    m_out   = pend.pop_front();
                    m_valid = 1;
                end else if (cons) begin
                    m_valid = 0;
                end
            end
        end
        @(negedge clk);
        check("id_valid", 64'(bus.id_valid), 64'(m_valid));
        check("if_ready", 64'(bus.if_ready), 64'(pend.size() == 0 && !rst));
        if (m_valid) begin
            e = ref_dec(m_out.instr);
            check("pc",      64'(bus.id_pc),      64'(m_out.pc));
            check("rs1_idx", 64'(bus.id_rs1_idx), 64'(m_out.instr[19:15]));
            check("rs2_idx", 64'(bus.id_rs2_idx), 64'(m_out.instr[24:20]));
            check("rd_idx",  64'(bus.id_rd_idx),  64'(m_out.instr[11:7]));
            check("fun3",    64'(bus.id_fun3),    64'(m_out.instr[14:12]));
            check("fun7",    64'(bus.id_fun7),    64'(m_out.instr[31:25]));
            check("fmt",     64'(bus.id_fmt),     64'(e.fmt));
            check("rs1_en",  64'(bus.id_rs1_en),  64'(e.rs1_en));
            check("rs2_en",  64'(bus.id_rs2_en),  64'(e.rs2_en));
            check("rd_en",   64'(bus.id_rd_en),   64'(e.rd_en));
            check("imm",     64'(bus.id_imm),     64'(e.imm[XLEN-1:0]));
            check("muldiv",  64'(bus.id_muldiv),  64'(e.muldiv));
            check("illegal", 64'(bus.id_illegal), 64'(e.illegal));
        end
    endtask

    task automatic offer(logic v, logic [31:0] pc, logic [31:0] w, logic exr, logic ldv, logic [4:0] ldrd, logic fl);
        bus.if_valid      = v;
        bus.if_pc         = pc;
        bus.if_instr      = w;
        bus.ex_ready      = exr;
        bus.ex_load_valid = ldv;
        bus.ex_load_rd    = ldrd;
        flush             = fl;
        cyc();
    endtask

    initial begin
        int idx;
        logic seen;
        bus.if_valid = 0; bus.if_pc = '0; bus.if_instr = '0;
        bus.ex_ready = 0; bus.ex_load_valid = 0; bus.ex_load_rd = '0;
        @(negedge clk);
        cyc();
        cyc();
        check("rst_imm", 64'(bus.id_imm), 64'd0);
        check("rst_fmt", 64'(bus.id_fmt), 64'd0);
        check("rst_pc",  64'(bus.id_pc),  64'd0);
        rst = 0;
        offer(0, 0, 0, 1, 0, 0, 0);

        offer(1, 32'h100, 32'hFFF10093, 1, 0, 0, 0);
        check("addi_valid", 64'(bus.id_valid), 64'd1);
        check("addi_fmt",   64'(bus.id_fmt), 64'd1);
        check("addi_rs1",   64'(bus.id_rs1_idx), 64'd2);
        check("addi_rd",    64'(bus.id_rd_idx), 64'd1);
        check("addi_en",    64'({bus.id_rs1_en, bus.id_rs2_en, bus.id_rd_en}), 64'b101);
        check("addi_imm",   64'(bus.id_imm), 64'hFFFFFFFF);
        offer(1, 32'h104, 32'h00512423, 1, 0, 0, 0);
        check("sw_fmt",   64'(bus.id_fmt), 64'd2);
        check("sw_rs",    64'({bus.id_rs1_idx, bus.id_rs2_idx}), 64'({5'd2, 5'd5}));
        check("sw_rd_en", 64'(bus.id_rd_en), 64'd0);
        check("sw_imm",   64'(bus.id_imm), 64'd8);
        offer(1, 32'h108, 32'hFE000EE3, 1, 0, 0, 0);
        check("beq_fmt", 64'(bus.id_fmt), 64'd3);
        check("beq_imm", 64'(bus.id_imm), 64'hFFFFFFFC);

        offer(1, 32'h10C, 32'h00728333, 1, 1, 5, 0);
        check("hz_bubble", 64'(bus.id_valid), 64'd0);
        offer(0, 0, 0, 1, 0, 0, 0);
        check("hz_issue", 64'({bus.id_valid, bus.id_rd_idx}), 64'({1'b1, 5'd6}));
        offer(1, 32'h110, 32'h00728333, 1, 1, 0, 0);
        check("x0_nostall", 64'({bus.id_valid, bus.id_pc}), 64'({1'b1, 32'h110}));
        offer(0, 0, 0, 1, 0, 0, 0);

        issued.delete();
        idx = 0;
        for (int k = 0; k < 10; k++) begin
            offer(idx < 4, 32'h200 + 32'(idx * 4), 32'h00100093 + (32'(idx) << 20), k >= 3, 0, 0, 0);
            if (k == 1)
                check("bp_full", 64'(bus.if_ready), 64'd0);
            if (m_acc)
                idx++;
        end
        check("bp_count", 64'(issued.size()), 64'd4);
        for (int i = 0; i < issued.size() && i < 4; i++)
            check("bp_order", 64'(issued[i].pc), 64'(32'h200 + 32'(i * 4)));

        issued.delete();
        offer(1, 32'h300, 32'h00100093, 0, 0, 0, 0);
        offer(1, 32'h304, 32'h00200113, 0, 0, 0, 0);
        offer(1, 32'h308, 32'h00300193, 0, 0, 0, 1);
        check("fl_valid", 64'(bus.id_valid), 64'd0);
        check("fl_ready", 64'(bus.if_ready), 64'd1);
        offer(1, 32'h308, 32'h00300193, 1, 0, 0, 1);
        for (int k = 0; k < 3; k++)
            offer(0, 0, 0, 1, 0, 0, 0);
        seen = 0;
        foreach (issued[i])
            if (issued[i].pc == 32'h308) seen = 1;
        check("fl_dropped", 64'(seen), 64'd0);

        offer(1, 32'h400, 32'h022081B3, 1, 0, 0, 0);
`ifdef DEC_RV32M_EN
        check("mul_flags", 64'({bus.id_muldiv, bus.id_illegal, bus.id_fmt}), 64'({1'b1, 1'b0, 3'd0}));
`else
        check("mul_flags", 64'({bus.id_muldiv, bus.id_illegal, bus.id_fmt}), 64'({1'b0, 1'b1, 3'd7}));
`endif
        offer(1, 32'h404, 32'h00000000, 1, 0, 0, 0);
        check("zero_illegal", 64'({bus.id_valid, bus.id_illegal, bus.id_fmt}), 64'({1'b1, 1'b1, 3'd7}));

        bus.if_valid = 0;
        m_acc = 0;
        for (int k = 0; k < 3000; k++) begin
            if (!bus.if_valid || m_acc) begin
                bus.if_valid = $urandom_range(0, 3) != 0;
                bus.if_pc    = next_pc;
                bus.if_instr = rand_instr();
                next_pc      = next_pc + 4;
            end
            bus.ex_ready      = $urandom_range(0, 3) != 0;
            bus.ex_load_valid = $urandom_range(0, 2) == 0;
            bus.ex_load_rd    = 5'($urandom_range(0, 7));
            flush             = $urandom_range(0, 40) == 0;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I/RV64I instruction-decode pipeline stage between IF and EX.
- Accepts {pc, instr} over a valid/ready handshake and buffers one entry in an internal skid register.
- Decodes all base opcode formats with correct rs/rd enables and sign-extended immediates.
- Detects load-use hazards against EX, inserts bubbles, and supports a pipeline flush.

Parameters:
- XLEN, 32, datapath width (32 or 64); the immediate is sign-extended to XLEN.
- PC_W, 32, PC width.
- REG_IDX_W, 5, register index width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all in-flight instructions.
- if_valid_i  in  1  IF presents an instruction.
- if_ready_o  out  1  stage accepts from IF; equals ~skid_valid & ~rst_i.
- if_pc_i  in  PC_W  instruction PC.
- if_instr_i  in  32  instruction word.
- ex_load_valid_i  in  1  EX holds a load.
- ex_load_rd_i  in  REG_IDX_W  destination register of that load.
- id_valid_o  out  1  decoded bundle valid.
- ex_ready_i  in  1  EX consumes the bundle.
- id_pc_o  out  PC_W  PC of the bundle.
- id_rs1_idx_o, id_rs2_idx_o, id_rd_idx_o  out  REG_IDX_W each  instr[19:15], instr[24:20], instr[11:7].
- id_rs1_en_o, id_rs2_en_o, id_rd_en_o  out  1 each  read rs1, read rs2, write rd.
- id_imm_o  out  XLEN  sign-extended immediate.
- id_fmt_o  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SYS/FENCE, 7=illegal.
- id_fun3_o  out  3  instr[14:12].
- id_fun7_o  out  7  instr[31:25].
- id_muldiv_o  out  1  M-extension operation.
- id_illegal_o  out  1  illegal instruction.

Behaviour:
- Reset: id_valid_o=0, skid_valid=0, all id_* data outputs=0, if_ready_o=0 while rst_i is high and 1 on the first cycle after.
- Head selection: head = skid entry if skid_valid, else the IF input. Decode is combinational on the head.
- hazard = ex_load_valid_i & (ex_load_rd_i != 0) & ((rs1_en & rs1 == ex_load_rd_i) | (rs2_en & rs2 == ex_load_rd_i)).
- load = head_valid & ~hazard & (~id_valid_o | ex_ready_i).
  - On load, the output register captures the bundle and id_valid_o=1.
  - On a consumed bundle (id_valid_o & ex_ready_i) with no load, id_valid_o=0. This is the bubble.
- Skid buffer:
  - An IF transfer (if_valid_i & if_ready_o) that is not loaded the same cycle is written into the skid register.
  - When a skid entry is loaded, skid_valid clears.
  - Order is always preserved. Latency is 1 cycle from IF accept to id_valid_o with no stall. Throughput is 1 per cycle.
- Output holding: while id_valid_o & ~ex_ready_i, all id_* outputs stay stable.
- Flush: flush_i has priority over everything else. Next cycle id_valid_o=0 and skid_valid=0. An IF transfer in the flush cycle is dropped.
- Decode table (opcode instr[6:0] → fmt, rs1/rs2/rd enables):
  - OP 0110011 → R, 1/1/1.
  - OP-IMM 0010011, LOAD 0000011, JALR 1100111 → I, 1/0/1.
  - STORE 0100011 → S, 1/1/0.
  - BRANCH 1100011 → B, 1/1/0.
  - LUI 0110111, AUIPC 0010111 → U, 0/0/1.
  - JAL 1101111 → J, 0/0/1.
  - FENCE 0001111, SYSTEM 1110011 → SYS, 0/0/0.
- Immediates:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R and SYS: 0.
  - All formats are sign-extended from instr[31] to XLEN.
- Overrides:
  - id_rd_en_o=0 when rd==0.
  - Illegal when the opcode is unlisted, instr[1:0]!=2'b11, or OP fun7 is not in the allowed set (see Optional Feature). Illegal forces fmt=7, all enables=0, imm=0, and still reports id_valid_o=1 so EX raises the trap.

Optional Feature:
- Macro: DEC_RV32M_EN.
- Defined: OP with fun7=0000001 is legal, id_muldiv_o=1, fmt=R.
- Undefined: fun7=0000001 is illegal and id_muldiv_o is tied to 0.
- In both cases OP fun7 values 0000000 and 0100000 are legal.

Test Plan:
- addi x1,x2,-1 (0xFFF10093) → fmt=1, rs1=2, rd=1, rs1_en=1, rs2_en=0, rd_en=1, imm=0xFFFFFFFF, id_valid_o one cycle after accept.
- sw x5,8(x2) (0x00512423) → fmt=2, rs1=2, rs2=5, rd_en=0, imm=8. beq x0,x0,-4 (0xFE000EE3) → fmt=3, imm=0xFFFFFFFC.
- Hazard: ex_load_valid_i=1, ex_load_rd_i=5, head add x6,x5,x7 → one bubble (id_valid_o=0), add issued the next cycle after the load flag drops. Same case with ex_load_rd_i=0 → no stall.
- Backpressure: 4 back-to-back instrs with ex_ready_i=0 for 3 cycles → if_ready_o=0 after the skid fills, no loss or duplication, issue order preserved.
- flush_i with a full skid and id_valid_o=1 → id_valid_o=0 and if_ready_o=1 the next cycle; the instruction offered during the flush is never issued.
- mul x3,x1,x2 (0x022081B3) → with DEC_RV32M_EN: muldiv=1, illegal=0. Without: illegal=1, fmt=7. Also instr 0x00000000 → illegal=1.
